// File: rtl/register_scoreboard_pkg.sv
// Shared types and defaults for the register scoreboard: register ID type,
// register-file sizing constants and the drain FSM state encoding.
package register_scoreboard_pkg;

    localparam int REG_NUM_REGS = 16;
    localparam int REG_ID_W     = 4;
    typedef logic [REG_ID_W-1:0] RegisterID;

    localparam int SB_MAX_PENDING = 3;
    localparam int SB_STALL_W     = 16;

    typedef enum logic [1:0] {
        SB_RUN,
        SB_DRAIN,
        SB_DONE
    } scoreboard_state_t;

    // Counter width able to hold 0..max_pending inclusive.
    function automatic int sb_cnt_w(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

endpackage

// File: rtl/register_scoreboard_counter.sv
// One per-register pending-write counter: increment on issue, decrement on
// writeback, clamped to [0, MAX_PENDING], with an underflow indication.
module sb_counter
    import register_scoreboard_pkg::*;
#(
    parameter int MAX_PENDING = SB_MAX_PENDING,
    parameter int CNT_W       = sb_cnt_w(SB_MAX_PENDING)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count_q,
    output logic [CNT_W-1:0] count_d,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

    always_comb begin
        count_d   = count_q;
        underflow = dec && (count_q == '0);
        // A simultaneous issue and retire on the same register cancel out.
        if (inc && !dec && (count_q != MAX_CNT)) begin
            count_d = count_q + CNT_W'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/register_scoreboard.sv
// Hazard controller between decode and the register file: tracks in-flight
// writes per register, gates issue on RAW / WAW-overflow, and handles drain.
module register_scoreboard
    import register_scoreboard_pkg::*;
#(
    parameter int NUM_REGS    = REG_NUM_REGS,
    parameter int REG_ID_W    = register_scoreboard_pkg::REG_ID_W,
    parameter int MAX_PENDING = SB_MAX_PENDING,
    parameter int STALL_W     = SB_STALL_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic                src0_valid,
    input  logic [REG_ID_W-1:0] src0_id,
    input  logic                src1_valid,
    input  logic [REG_ID_W-1:0] src1_id,
    input  logic                dst_valid,
    input  logic [REG_ID_W-1:0] dst_id,
    input  logic                wb_valid,
    input  logic [REG_ID_W-1:0] wb_id,
    input  logic                drain_req,
    output logic                drain_done,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [STALL_W-1:0]  stall_cycles,
    output logic                sb_error
);

    localparam int CNT_W    = sb_cnt_w(MAX_PENDING);
    localparam int ID_SPACE = 2 ** REG_ID_W;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

    logic [CNT_W-1:0]    cnt_q [ID_SPACE];
    logic [CNT_W-1:0]    cnt_d [ID_SPACE];
    logic [ID_SPACE-1:0] id_legal;
    logic [ID_SPACE-1:0] under_vec;

    scoreboard_state_t state_q, state_d;
    logic [NUM_REGS-1:0] busy_mask_q, busy_mask_d;
    logic                drain_done_q, drain_done_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                sb_error_q, sb_error_d;

    logic src0_ok, src1_ok, dst_ok, wb_ok;
    logic hazard, fire, inc_en, dec_en, all_zero_d, bad_id;

    // The ID space is padded to a power of two so that any ID indexes safely;
    // slots beyond NUM_REGS read as empty and are flagged as illegal.
    generate
        for (genvar gi = 0; gi < ID_SPACE; gi++) begin : g_slot
            if (gi < NUM_REGS) begin : g_reg
                logic inc_i, dec_i;
                assign id_legal[gi] = 1'b1;
                assign inc_i = inc_en && (dst_id == REG_ID_W'(gi));
                assign dec_i = dec_en && (wb_id == REG_ID_W'(gi));
                sb_counter #(
                    .MAX_PENDING (MAX_PENDING),
                    .CNT_W       (CNT_W)
                ) u_cnt (
                    .clk       (clk),
                    .reset     (reset),
                    .inc       (inc_i),
                    .dec       (dec_i),
                    .count_q   (cnt_q[gi]),
                    .count_d   (cnt_d[gi]),
                    .underflow (under_vec[gi])
                );
            end else begin : g_pad
                assign id_legal[gi]  = 1'b0;
                assign cnt_q[gi]     = '0;
                assign cnt_d[gi]     = '0;
                assign under_vec[gi] = 1'b0;
            end
        end
    endgenerate

    assign src0_ok = id_legal[src0_id];
    assign src1_ok = id_legal[src1_id];
    assign dst_ok  = id_legal[dst_id];
    assign wb_ok   = id_legal[wb_id];

    // No writeback bypass: hazards look only at the registered counters.
    assign hazard = (src0_valid && src0_ok && (cnt_q[src0_id] != '0))
                  | (src1_valid && src1_ok && (cnt_q[src1_id] != '0))
                  | (dst_valid  && dst_ok  && (cnt_q[dst_id] == MAX_CNT));

    assign issue_ready = (state_q == SB_RUN) && !hazard;
    assign fire        = issue_valid && issue_ready;
    assign inc_en      = fire && dst_valid && dst_ok;
    assign dec_en      = wb_valid && wb_ok;

    assign bad_id = (wb_valid && !wb_ok)
                  | (issue_valid && ((src0_valid && !src0_ok)
                                   | (src1_valid && !src1_ok)
                                   | (dst_valid  && !dst_ok)));

    always_comb begin
        all_zero_d  = 1'b1;
        busy_mask_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_mask_d[i] = (cnt_d[i] != '0);
            if (cnt_d[i] != '0) begin
                all_zero_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SB_RUN:   if (drain_req) state_d = SB_DRAIN;
            SB_DRAIN: begin
                if (!drain_req) begin
                    state_d = SB_RUN;
                end else if (all_zero_d) begin
                    state_d = SB_DONE;
                end
            end
            SB_DONE:  if (!drain_req) state_d = SB_RUN;
            default:  state_d = SB_RUN;
        endcase
    end

    always_comb begin
        drain_done_d = (state_d == SB_DONE);
        sb_error_d   = sb_error_q || bad_id || (|under_vec);
        stall_d      = stall_q;
        if ((state_q == SB_RUN) && issue_valid && !issue_ready && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SB_RUN;
            busy_mask_q  <= '0;
            drain_done_q <= 1'b0;
            stall_q      <= '0;
            sb_error_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            busy_mask_q  <= busy_mask_d;
            drain_done_q <= drain_done_d;
            stall_q      <= stall_d;
            sb_error_q   <= sb_error_d;
        end
    end

    assign busy_mask    = busy_mask_q;
    assign drain_done   = drain_done_q;
    assign stall_cycles = stall_q;
    assign sb_error     = sb_error_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// Randomized scoreboard bench for register_scoreboard: a reference model
// queues expected outputs per cycle and a monitor compares the DUT against them.
module tb_register_scoreboard;
    import register_scoreboard_pkg::*;

    localparam int N    = 16;
    localparam int W    = 4;
    localparam int MAXP = 3;
    localparam int SW   = 16;

    localparam int RUNNING  = 0;
    localparam int DRAINING = 1;
    localparam int QUIESCED = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid, issue_ready;
    logic          src0_valid, src1_valid, dst_valid, wb_valid;
    RegisterID     src0_id, src1_id, dst_id, wb_id;
    logic          drain_req, drain_done;
    logic [N-1:0]  busy_mask;
    logic [SW-1:0] stall_cycles;
    logic          sb_error;

    always #5 clk = ~clk;

    register_scoreboard #(
        .NUM_REGS    (N),
        .REG_ID_W    (W),
        .MAX_PENDING (MAXP),
        .STALL_W     (SW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .src0_valid   (src0_valid),
        .src0_id      (src0_id),
        .src1_valid   (src1_valid),
        .src1_id      (src1_id),
        .dst_valid    (dst_valid),
        .dst_id       (dst_id),
        .wb_valid     (wb_valid),
        .wb_id        (wb_id),
        .drain_req    (drain_req),
        .drain_done   (drain_done),
        .busy_mask    (busy_mask),
        .stall_cycles (stall_cycles),
        .sb_error     (sb_error)
    );

    typedef struct {
        logic          ready;
        logic [N-1:0]  busy;
        logic          done;
        logic [SW-1:0] stall;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: pending counts as plain integers plus a drain mode.
    int pend[N];
    int mode;
    int stall_m;
    bit err_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) pend[i] = 0;
        mode    = RUNNING;
        stall_m = 0;
        err_m   = 1'b0;
    endtask

    task automatic cyc(input bit iv, input bit s0v, input int s0, input bit s1v, input int s1,
                       input bit dv, input int d, input bit wbv, input int wb, input bit dr);
        exp_t e;
        int   np[N];
        bit   hz, fire, allz;
        @(posedge clk);
        #2;
        reset       = 1'b0;
        issue_valid = iv;
        src0_valid  = s0v;  src0_id = W'(s0);
        src1_valid  = s1v;  src1_id = W'(s1);
        dst_valid   = dv;   dst_id  = W'(d);
        wb_valid    = wbv;  wb_id   = W'(wb);
        drain_req   = dr;

        hz = (s0v && pend[s0] != 0) || (s1v && pend[s1] != 0) || (dv && pend[d] == MAXP);
        e.ready = (mode == RUNNING) && !hz;
        fire = iv && e.ready;
        np = pend;
        if (wbv && pend[wb] == 0) err_m = 1'b1;
        if (!(fire && dv && wbv && d == wb)) begin
            if (fire && dv) np[d]++;
            if (wbv && pend[wb] > 0) np[wb]--;
        end
        if (mode == RUNNING && iv && !e.ready && stall_m < 65535) stall_m++;
        allz = 1'b1;
        for (int i = 0; i < N; i++) if (np[i] != 0) allz = 1'b0;
        case (mode)
            RUNNING:  if (dr) mode = DRAINING;
            DRAINING: if (!dr) mode = RUNNING; else if (allz) mode = QUIESCED;
            default:  if (!dr) mode = RUNNING;
        endcase
        pend = np;
        for (int i = 0; i < N; i++) e.busy[i] = (pend[i] != 0);
        e.done  = (mode == QUIESCED);
        e.stall = SW'(stall_m);
        e.err   = err_m;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        exp_t e;
        @(posedge clk);
        #2;
        reset       = 1'b1;
        issue_valid = 1'b0;
        src0_valid  = 1'b0;
        src1_valid  = 1'b0;
        dst_valid   = 1'b0;
        wb_valid    = 1'b0;
        drain_req   = 1'b0;
        model_clear();
        e.ready = 1'b1;
        e.busy  = '0;
        e.done  = 1'b0;
        e.stall = '0;
        e.err   = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit dr);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, dr);
    endtask

    // Monitor: issue_ready checked mid-cycle, registered outputs after the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                mon_e = exp_q[0];
                check("issue_ready", 32'(issue_ready), 32'(mon_e.ready));
                @(posedge clk);
                #1;
                check("busy_mask", 32'(busy_mask), 32'(mon_e.busy));
                check("drain_done", 32'(drain_done), 32'(mon_e.done));
                check("stall_cycles", 32'(stall_cycles), 32'(mon_e.stall));
                check("sb_error", 32'(sb_error), 32'(mon_e.err));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int drain_len;
        int wbr;
        bit wbv;
        reset       = 1'b1;
        issue_valid = 1'b0;
        src0_valid  = 1'b0;  src0_id = '0;
        src1_valid  = 1'b0;  src1_id = '0;
        dst_valid   = 1'b0;  dst_id  = '0;
        wb_valid    = 1'b0;  wb_id   = '0;
        drain_req   = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        do_reset();

        // RAW on R3, cleared by writeback (no same-cycle bypass)
        cyc(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        cyc(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 3, 0, 0, 0, 0, 1, 3, 0);
        cyc(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);

        // WAW overflow on R5
        repeat (4) cyc(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        idle(0);

        // Same-cycle issue and retire on R2
        cyc(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 2, 1, 2, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 2, 0);

        // Writeback underflow on R7 is sticky
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        cyc(1, 0, 0, 0, 0, 1, 8, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 8, 0);
        idle(0);
        do_reset();

        // Drain with outstanding writes; issue accepted as drain_req rises
        cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 9, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 1, 10, 1, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 9, 1);
        idle(1);
        cyc(1, 0, 0, 0, 0, 1, 11, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 11, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 11, 0);

        // Drain while already quiescent, and drain abandoned mid-way
        repeat (3) idle(1);
        idle(0);
        cyc(1, 0, 0, 0, 0, 1, 6, 0, 0, 1);
        idle(1);
        idle(0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 6, 0);

        // Randomized traffic; writebacks only target registers with pending writes
        drain_len = 0;
        for (int n = 0; n < 3000; n++) begin
            bit dr;
            if (drain_len > 0) begin
                dr = 1'b1;
                drain_len--;
            end else begin
                dr = 1'b0;
                if ($urandom_range(0, 39) == 0) drain_len = $urandom_range(2, 12);
            end
            wbv = 1'b0;
            wbr = 0;
            if ($urandom_range(0, 1) == 1) begin
                int start = $urandom_range(0, N - 1);
                for (int k = 0; k < N; k++) begin
                    int r = (start + k) % N;
                    if (!wbv && pend[r] > 0) begin
                        wbv = 1'b1;
                        wbr = r;
                    end
                end
            end
            cyc($urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, N - 1),
                $urandom_range(0, 1) == 1, $urandom_range(0, N - 1),
                $urandom_range(0, 2) != 0, $urandom_range(0, N - 1),
                wbv, wbr, dr);
        end

        // Reset mid-stream with R4 pending and the scoreboard draining
        do_reset();
        cyc(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        cyc(1, 1, 4, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        do_reset();
        cyc(1, 1, 4, 0, 0, 1, 4, 0, 0, 0);
        idle(0);

        for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
